// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states and frame layout.
package imem_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int unsigned HDR_BYTES     = 2;
  localparam int unsigned CHK_BYTES     = 1;
  localparam int unsigned MAX_WORDS_DEF = 4096;

  // States in which the loader accepts a byte from the stream.
  function automatic logic rx_state(input state_t s);
    return s inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CHECK};
  endfunction

endpackage

// File: rtl/imem_loader_chk.sv
// 8-bit XOR checksum accumulator; match compares the incoming byte with the running sum.
module imem_loader_chk (
  input  logic       clock,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] byte_i,
  output logic       match_o
);

  logic [7:0] acc_q;

  always_ff @(posedge clock) begin
    if (!reset || clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q ^ byte_i;
    end
  end

  assign match_o = (byte_i == acc_q);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader writing 16-bit big-endian words into instruction memory,
// verifying a trailing XOR checksum and holding the CPU in reset until success.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS  = MAX_WORDS_DEF,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [15:0]           mem_data,
  output logic                  mem_wren,
  output logic                  cpu_reset,
  output logic [15:0]           loaded_words,
  output logic                  done,
  output logic                  error
);

  state_t                state_q, state_d;
  logic [15:0]           len_q;
  logic [15:0]           len_next;
  logic [ADDR_WIDTH-1:0] mem_address_q;
  logic [15:0]           mem_data_q;
  logic [15:0]           loaded_words_q;
  logic                  rx_ready_q, mem_wren_q, cpu_reset_q, done_q, error_q;
  logic                  accept, last_word, chk_clr, chk_en, chk_match;

  assign accept    = rx_valid && rx_ready_q;
  assign len_next  = {len_q[7:0], rx_data};
  assign last_word = ((loaded_words_q + 16'd1) == len_q);
  assign chk_clr   = start && (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign chk_en    = accept && (state_q inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO});

  imem_loader_chk u_chk (
    .clock   (clock),
    .reset   (reset),
    .clr_i   (chk_clr),
    .en_i    (chk_en),
    .byte_i  (rx_data),
    .match_o (chk_match)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) state_d = ST_LEN_HI;
      ST_LEN_HI:  if (accept) state_d = ST_LEN_LO;
      ST_LEN_LO: begin
        if (accept) begin
          if (32'(len_next) > MAX_WORDS) state_d = ST_ERROR;
          else if (len_next == '0)       state_d = ST_CHECK;
          else                           state_d = ST_DATA_HI;
        end
      end
      ST_DATA_HI: if (accept) state_d = ST_DATA_LO;
      ST_DATA_LO: if (accept) state_d = ST_WRITE;
      ST_WRITE:   state_d = last_word ? ST_CHECK : ST_DATA_HI;
      ST_CHECK:   if (accept) state_d = chk_match ? ST_DONE : ST_ERROR;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      mem_address_q  <= '0;
      mem_data_q     <= '0;
      loaded_words_q <= '0;
      rx_ready_q     <= 1'b0;
      mem_wren_q     <= 1'b0;
      cpu_reset_q    <= 1'b1;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_state(state_d);
      mem_wren_q <= (state_d == ST_WRITE);

      if (chk_clr) begin
        done_q         <= 1'b0;
        error_q        <= 1'b0;
        loaded_words_q <= '0;
        mem_address_q  <= '0;
        len_q          <= '0;
        cpu_reset_q    <= 1'b1;
      end

      if (accept && (state_q inside {ST_LEN_HI, ST_LEN_LO})) len_q <= len_next;
      if (accept && state_q == ST_DATA_HI) mem_data_q[15:8] <= rx_data;
      if (accept && state_q == ST_DATA_LO) mem_data_q[7:0]  <= rx_data;

      // The address stops on the final word so it never leaves 0..MAX_WORDS-1.
      if (state_q == ST_WRITE) begin
        loaded_words_q <= loaded_words_q + 16'd1;
        if (!last_word) mem_address_q <= mem_address_q + ADDR_WIDTH'(1);
      end

      if (state_q == ST_CHECK && state_d == ST_DONE) begin
        done_q      <= 1'b1;
        cpu_reset_q <= 1'b0;
      end
      if (state_q != ST_ERROR && state_d == ST_ERROR) error_q <= 1'b1;
    end
  end

  assign rx_ready     = rx_ready_q;
  assign mem_address  = mem_address_q;
  assign mem_data     = mem_data_q;
  assign mem_wren     = mem_wren_q;
  assign cpu_reset    = cpu_reset_q;
  assign loaded_words = loaded_words_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus random frames against a frame-level model.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int unsigned MAXW = 4;
  localparam int unsigned AW   = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [AW-1:0] mem_address;
  logic [15:0]   mem_data;
  logic          mem_wren;
  logic          cpu_reset;
  logic [15:0]   loaded_words;
  logic          done;
  logic          error;

  imem_loader #(.MAX_WORDS(MAXW), .ADDR_WIDTH(AW)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_wren     (mem_wren),
    .cpu_reset    (cpu_reset),
    .loaded_words (loaded_words),
    .done         (done),
    .error        (error)
  );

  always #5 clock = ~clock;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Passive monitor: only this block writes these; the stimulus reads snapshots.
  logic [31:0] wr_q[$];
  int unsigned consumed     = 0;
  int unsigned rdy_in_write = 0;

  always @(negedge clock) begin
    if (reset) begin
      if (mem_wren) wr_q.push_back({mem_address, mem_data});
      if (rx_valid && rx_ready) consumed++;
      if (mem_wren && rx_ready) rdy_in_write++;
    end
  end

  logic [7:0] byte_q[$];

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap, output bit ok);
    logic rdy;
    repeat (gap) @(posedge clock);
    if (gap != 0) #1;
    rx_valid = 1'b1;
    rx_data  = b;
    ok = 1'b0;
    for (int unsigned c = 0; c < 64 && !ok; c++) begin
      @(negedge clock);
      rdy = rx_ready;
      @(posedge clock); #1;
      if (rdy) ok = 1'b1;
    end
    rx_valid = 1'b0;
  endtask

  // gap_mode: 0 none, 1 five idle cycles before every WORD_LO, 2 random gaps.
  task automatic run_frame(input string name, input int unsigned gap_mode);
    int unsigned n, nbytes_exp, w0, c0, r0, gap;
    logic [7:0]  x;
    bit          oversize, good, ok, exp_done;
    logic [31:0] exp_w[$];
    logic [31:0] got;

    n        = 32'({byte_q[0], byte_q[1]});
    oversize = (n > MAXW);
    good     = 1'b0;
    if (!oversize) begin
      x = '0;
      for (int unsigned i = 0; i + 1 < byte_q.size(); i++) x ^= byte_q[i];
      good = (x == byte_q[byte_q.size()-1]);
      for (int unsigned i = 0; i < n; i++)
        exp_w.push_back({i[15:0], byte_q[HDR_BYTES+2*i], byte_q[HDR_BYTES+2*i+1]});
      nbytes_exp = HDR_BYTES + 2*n + CHK_BYTES;
    end else begin
      nbytes_exp = HDR_BYTES;
    end
    exp_done = !oversize && good;

    w0 = wr_q.size(); c0 = consumed; r0 = rdy_in_write;
    pulse_start();
    @(negedge clock);
    check_eq({name, " start cpu_reset"}, 32'(cpu_reset), 1);
    check_eq({name, " start flags"}, {30'd0, done, error}, 0);
    check_eq({name, " start loaded"}, 32'(loaded_words), 0);
    @(posedge clock); #1;

    for (int unsigned idx = 0; idx < byte_q.size(); idx++) begin
      gap = 0;
      if (gap_mode == 1 && idx > HDR_BYTES && idx < HDR_BYTES + 2*n && ((idx - HDR_BYTES) % 2) == 1)
        gap = 5;
      else if (gap_mode == 2)
        gap = $urandom_range(0, 3);
      send_byte(byte_q[idx], gap, ok);
      if (!ok) begin
        check_eq({name, " byte timeout"}, 0, 1);
        break;
      end
    end

    @(negedge clock);
    check_eq({name, " done"}, 32'(done), 32'(exp_done));
    check_eq({name, " error"}, 32'(error), 32'(!exp_done));
    check_eq({name, " cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
    check_eq({name, " ready after end"}, 32'(rx_ready), 0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq({name, " ready idle"}, 32'(rx_ready), 0);
    check_eq({name, " wren idle"}, 32'(mem_wren), 0);
    check_eq({name, " loaded_words"}, 32'(loaded_words), oversize ? 0 : n);
    check_eq({name, " write count"}, wr_q.size() - w0, exp_w.size());
    for (int unsigned i = 0; i < exp_w.size(); i++) begin
      got = (w0 + i < wr_q.size()) ? wr_q[w0+i] : 'x;
      check_eq({name, " write"}, got, exp_w[i]);
    end
    check_eq({name, " bytes consumed"}, consumed - c0, nbytes_exp);
    check_eq({name, " ready in write"}, rdy_in_write - r0, 0);
    @(posedge clock); #1;
  endtask

  task automatic load_normal(input logic [7:0] chk);
    byte_q = {8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, chk};
  endtask

  initial begin
    int unsigned n, w0;
    logic [7:0]  x;
    bit          ok;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("reset outputs", {27'd0, rx_ready, mem_wren, cpu_reset, done, error}, 32'b00100);
    check_eq("reset address", 32'(mem_address), 0);
    check_eq("reset data", 32'(mem_data), 0);
    check_eq("reset loaded", 32'(loaded_words), 0);
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("idle ready", 32'(rx_ready), 0);
    @(posedge clock); #1;

    load_normal(8'h42); run_frame("normal", 0);
    load_normal(8'h43); run_frame("badchk", 0);
    byte_q = {8'h00, 8'h00, 8'h00}; run_frame("empty", 0);
    byte_q = {8'h00, 8'h05}; run_frame("oversize", 0);
    load_normal(8'h42); run_frame("stall", 1);

    // Reset while waiting for WORD_LO of word 1.
    w0 = wr_q.size();
    pulse_start();
    byte_q = {8'h00, 8'h03, 8'h12, 8'h34, 8'hAB};
    foreach (byte_q[i]) send_byte(byte_q[i], 0, ok);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check_eq("midreset address", 32'(mem_address), 0);
    check_eq("midreset outputs", {28'd0, rx_ready, mem_wren, cpu_reset, done}, 32'b0010);
    check_eq("midreset error", 32'(error), 0);
    repeat (4) @(posedge clock);
    @(negedge clock);
    check_eq("midreset writes", wr_q.size() - w0, 1);
    check_eq("midreset word0", (w0 < wr_q.size()) ? wr_q[w0] : 'x, 32'h0000_1234);
    @(posedge clock); #1;
    load_normal(8'h42); run_frame("after reset", 0);

    for (int unsigned f = 0; f < 25; f++) begin
      n = $urandom_range(0, MAXW + 2);
      byte_q = {8'h00, 8'(n)};
      if (n <= MAXW) begin
        for (int unsigned i = 0; i < 2*n; i++) byte_q.push_back(8'($urandom));
        x = '0;
        foreach (byte_q[i]) x ^= byte_q[i];
        if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
        byte_q.push_back(x);
      end
      run_frame("random", 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory port that the fetch stage reads.
- Accepts a framed byte stream over a valid/ready handshake, assembles big-endian 16-bit instruction words and writes them to consecutive instruction-memory addresses from 0.
- Verifies a trailing XOR checksum.
- Holds the processor in reset until a load completes successfully.

Parameters:
- MAX_WORDS, 4096: largest accepted word count; a larger count is a framing error.
- ADDR_WIDTH, 16: width of the memory address output.

Ports:
- clock  in  1  single system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader can accept a byte this cycle.
- mem_address  out  ADDR_WIDTH  instruction-memory write address.
- mem_data  out  16  instruction-memory write data.
- mem_wren  out  1  write strobe, one cycle per word.
- cpu_reset  out  1  active-high reset to the processor stages.
- loaded_words  out  16  count of words written in the current or last load.
- done  out  1  load completed and checksum matched.
- error  out  1  checksum mismatch or oversize count.

Behaviour:
- Reset (reset==0 at posedge), regardless of current state:
  - state=IDLE; mem_address=0, mem_data=0, loaded_words=0; mem_wren=0, rx_ready=0, done=0, error=0; cpu_reset=1.
  - Checksum accumulator=0, length register=0.
  - A load in progress is abandoned with no further writes; words already written stay in memory.
- Byte transfer: occurs at a posedge with rx_valid && rx_ready. The loader never consumes a byte without rx_ready. rx_valid gaps stall the FSM with all registers held.
- Frame format: LEN_HI, LEN_LO (16-bit word count N), then N x (WORD_HI, WORD_LO), then CHK. CHK must equal the XOR of every preceding byte of the frame, including both length bytes.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR: rx_ready=0. On start:
  - go to LEN_HI; clear done, error, loaded_words, mem_address and checksum.
  - set cpu_reset=1.
- LEN_HI, LEN_LO: rx_ready=1; each byte shifts into the length register and XORs into the checksum. After LEN_LO is accepted:
  - N > MAX_WORDS -> ERROR.
  - N == 0 -> CHECK.
  - otherwise -> DATA_HI.
- DATA_HI: rx_ready=1; byte goes to mem_data[15:8].
- DATA_LO: rx_ready=1; byte goes to mem_data[7:0]; next state WRITE.
- WRITE: exactly one cycle.
  - mem_wren=1, rx_ready=0; mem_address holds the word index.
  - On exit: mem_address++, loaded_words++.
  - If loaded_words+1 == N -> CHECK, else -> DATA_HI.
- Latency: one write per word, in the cycle after WORD_LO is accepted. Max throughput is one word per 3 cycles.
- CHECK: rx_ready=1. On acceptance, compare the byte with the accumulator:
  - equal -> DONE: done=1, cpu_reset=0 from the next cycle.
  - else -> ERROR: error=1, cpu_reset stays 1.
- start while in LEN_HI..CHECK is ignored.
- mem_wren is low in every state except WRITE. mem_address never exceeds MAX_WORDS-1.
- Arithmetic: mem_address and loaded_words are unsigned with no wrap, guaranteed by the MAX_WORDS check. The checksum is 8-bit XOR.

Decomposition:
- Shared package: state enumeration; frame constants (header length 2, checksum length 1); MAX_WORDS default.
- One natural sub-module, imem_loader_chk: 8-bit XOR accumulator with clear/enable inputs and a compare output.
- The FSM and datapath stay in imem_loader.

Test Plan:
- Normal load: start, then bytes 00,03,12,34,AB,CD,00,01,42 with rx_valid held high.
  - Required: writes (0,0x1234), (1,0xABCD), (2,0x0001), one mem_wren cycle each.
  - Then done=1, error=0, loaded_words=3, cpu_reset=0.
- Bad checksum: same frame with final byte 43 instead of 42.
  - Required: the three writes still occur; error=1, done=0, cpu_reset remains 1.
- Empty program: bytes 00,00,00.
  - Required: no mem_wren pulses; done=1, loaded_words=0.
- Oversize count (MAX_WORDS=4): bytes 00,05.
  - Required: ERROR right after the second byte; rx_ready=0 afterwards; no writes.
- Stall/backpressure: insert 5-cycle rx_valid gaps between WORD_HI and WORD_LO.
  - Required: identical writes to the normal-load case; no extra bytes consumed; rx_ready=0 during each WRITE cycle.
- Reset mid-load: drive reset=0 for one cycle while in DATA_LO of word 1.
  - Required: IDLE, mem_address=0, no write of word 1, cpu_reset=1.
  - A subsequent start followed by the full normal-load frame loads correctly.
